a2d_intf: RTL



---
 rtl/a2d_intf.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/a2d_intf.sv
// a2d_intf: SPI master that reads left load cell, right load cell and battery from the A2D on each nxt.
// Optional A2D_FILT_EN: each result becomes the average of its previous value and the new sample.
module a2d_intf #(
  parameter logic [2:0]  LFT_CH   = 3'd0,
  parameter logic [2:0]  RGHT_CH  = 3'd4,
  parameter logic [2:0]  BATT_CH  = 3'd5,
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        busy,
  output logic        cnv_cmplt
);

  localparam int unsigned H  = SCLK_DIV / 2;
  localparam int          CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
  localparam logic [CW-1:0] H_CNT    = CW'(H);
  localparam logic [CW-1:0] PER_LAST = CW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP, DONE} state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [1:0]    ch;
  logic [15:0]   tx_shft;
  logic [11:0]   rx_shft;
  logic          phase_end;
  logic          ss_n_d, sclk_d;
  logic          load_en;

  function automatic logic [2:0] ch_addr(input logic [1:0] c);
    case (c)
      2'd0:    ch_addr = LFT_CH;
      2'd1:    ch_addr = RGHT_CH;
      default: ch_addr = BATT_CH;
    endcase
  endfunction

  function automatic logic [15:0] cmd_word(input logic [1:0] c);
    cmd_word = {2'b00, ch_addr(c), 11'h000};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= nxt_state;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // cnt times each phase; in SHIFT it wraps once per SCLK period and bit_cnt counts periods.
  always_comb begin
    nxt_state   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    phase_end   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (nxt) nxt_state = FRONT;
      end
      FRONT: begin
        bit_cnt_nxt = '0;
        if (cnt == H_LAST) begin
          phase_end = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == PER_LAST) begin
          phase_end   = 1'b1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 4'd15) nxt_state = BACK;
        end
      end
      BACK: begin
        if (cnt == H_LAST) begin
          phase_end = 1'b1;
          nxt_state = (ch == 2'd2) ? DONE : GAP;
        end
      end
      GAP: begin
        if (cnt == PER_LAST) begin
          phase_end = 1'b1;
          nxt_state = FRONT;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    if (phase_end) cnt_nxt = '0;
  end

  // SS_n and SCLK are computed from the upcoming state so their flops line up with state.
  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    cnv_cmplt = (state == DONE);
    ss_n_d    = !((nxt_state == FRONT) || (nxt_state == SHIFT) || (nxt_state == BACK));
    sclk_d    = !((nxt_state == SHIFT) && (cnt_nxt < H_CNT));
  end

  // Only the low 12 received bits are kept; the upper nibble simply shifts out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
      ch      <= 2'd0;
      tx_shft <= 16'h0000;
      rx_shft <= 12'h000;
    end else begin
      SS_n <= ss_n_d;
      SCLK <= sclk_d;
      if ((state == IDLE) && nxt) begin
        ch      <= 2'd0;
        tx_shft <= cmd_word(2'd0);
      end else if ((state == GAP) && phase_end) begin
        ch      <= ch + 1'b1;
        tx_shft <= cmd_word(ch + 1'b1);
      end else if ((state == SHIFT) && (cnt == PER_LAST) && (bit_cnt != 4'd15)) begin
        tx_shft <= {tx_shft[14:0], 1'b0};
      end
      if ((state == SHIFT) && (cnt == H_LAST)) rx_shft <= {rx_shft[10:0], MISO};
    end
  end

  assign MOSI    = tx_shft[15];
  assign load_en = (state == BACK) && (cnt == H_LAST);

`ifdef A2D_FILT_EN
  logic [2:0] seen;

  function automatic logic [11:0] blend(input logic [11:0] old_v, input logic [11:0] raw,
                                        input logic valid);
    logic [12:0] sum;
    sum   = {1'b0, old_v} + {1'b0, raw};
    blend = valid ? sum[12:1] : raw;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
      batt    <= 12'h000;
      seen    <= 3'b000;
    end else if (load_en) begin
      case (ch)
        2'd0: begin
          lft_ld  <= blend(lft_ld, rx_shft, seen[0]);
          seen[0] <= 1'b1;
        end
        2'd1: begin
          rght_ld <= blend(rght_ld, rx_shft, seen[1]);
          seen[1] <= 1'b1;
        end
        default: begin
          batt    <= blend(batt, rx_shft, seen[2]);
          seen[2] <= 1'b1;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
      batt    <= 12'h000;
    end else if (load_en) begin
      case (ch)
        2'd0:    lft_ld  <= rx_shft;
        2'd1:    rght_ld <= rx_shft;
        default: batt    <= rx_shft;
      endcase
    end
  end
`endif

  // SCLK may only toggle while the chip select is active.
  a_sclk_idle: assert property (@(posedge clk) disable iff (!rst_n) SS_n |-> SCLK);

endmodule
